// File: rtl/norm_multi.sv
// Multi-channel cumulative normal N(d) using the Abramowitz-Stegun polynomial, channels in sequence.
// Optional magnitude clamp (|d| >= 6 skips the datapath) is enabled by defining NORM_CLAMP_EN.
module norm_multi #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter int CHANNELS = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [CHANNELS*WIDTH-1:0] d_i,
    output logic [CHANNELS*WIDTH-1:0] N_o,
    output logic                      done_o,
    output logic                      busy_o,
    output logic                      exp_start_o,
    output logic [WIDTH-1:0]          exp_x_o,
    input  logic [WIDTH-1:0]          exp_y_i,
    input  logic                      exp_done_i
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    function automatic logic [WIDTH-1:0] qc(input real v);
        real s;
        s = v * (2.0 ** FRAC);
        if (s < 0.0) return WIDTH'(-$rtoi(-s + 0.5));
        return WIDTH'($rtoi(s + 0.5));
    endfunction

    localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0]   C_GAMMA  = qc(0.2316419);
    localparam logic [WIDTH-1:0]   C_INVS   = qc(0.39894228);
    localparam logic [WIDTH-1:0]   C_A1     = qc(0.31938153);
    localparam logic [WIDTH-1:0]   C_A2     = qc(-0.35656378);
    localparam logic [WIDTH-1:0]   C_A3     = qc(1.78147794);
    localparam logic [WIDTH-1:0]   C_A4     = qc(-1.82125598);
    localparam logic [WIDTH-1:0]   C_A5     = qc(1.33027443);
    localparam logic [2*WIDTH-1:0] DIVIDEND = (2*WIDTH)'(ONE) << FRAC;
`ifdef NORM_CLAMP_EN
    localparam logic [WIDTH-1:0]   CLAMP    = WIDTH'(6) << FRAC;
`endif

    // Signed Q-format multiply: full-width product, truncated back to WIDTH.
    function automatic logic [WIDTH-1:0] mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] pr;
        pr = (2*WIDTH)'($signed(a)) * (2*WIDTH)'($signed(b));
        return WIDTH'(pr >>> FRAC);
    endfunction

    typedef enum logic [3:0] {
        S_IDLE, S_ABS, S_SQ, S_HALF, S_EXP_REQ, S_EXP_WAIT,
        S_NPRIME, S_GAMMA, S_DIV, S_POLY, S_FINAL, S_DONE
    } state_t;

    state_t                             state_q, state_d;
    logic [CW-1:0]                      ch_q, ch_d;
    logic [CHANNELS-1:0][WIDTH-1:0]     d_q, d_d;
    logic [CHANNELS-1:0][WIDTH-1:0]     res_q, res_d;
    logic [CHANNELS-1:0][WIDTH-1:0]     n_out_q, n_out_d;
    logic [WIDTH-1:0]                   x_q, x_d;
    logic                               neg_q, neg_d;
    logic [WIDTH-1:0]                   a_q, a_d;
    logic [WIDTH-1:0]                   e_q, e_d;
    logic [WIDTH-1:0]                   n_q, n_d;
    logic [WIDTH-1:0]                   den_q, den_d;
    logic [WIDTH-1:0]                   k_q, k_d;
    logic [WIDTH-1:0]                   p_q, p_d;
    logic [2:0]                         pcnt_q, pcnt_d;
    logic                               done_q, done_d;
    logic                               busy_q, busy_d;
    logic                               exp_start_q, exp_start_d;
    logic [WIDTH-1:0]                   exp_x_q, exp_x_d;

    logic [WIDTH-1:0] d_cur, abs_x, q_val;
    logic             last_ch;

    assign d_cur   = d_q[ch_q];
    assign abs_x   = d_cur[WIDTH-1] ? (-d_cur) : d_cur;
    assign last_ch = (ch_q == CW'(CHANNELS - 1));
    assign q_val   = mul(n_q, p_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            d_q         <= '0;
            res_q       <= '0;
            n_out_q     <= '0;
            x_q         <= '0;
            neg_q       <= 1'b0;
            a_q         <= '0;
            e_q         <= '0;
            n_q         <= '0;
            den_q       <= '0;
            k_q         <= '0;
            p_q         <= '0;
            pcnt_q      <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            exp_start_q <= 1'b0;
            exp_x_q     <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            d_q         <= d_d;
            res_q       <= res_d;
            n_out_q     <= n_out_d;
            x_q         <= x_d;
            neg_q       <= neg_d;
            a_q         <= a_d;
            e_q         <= e_d;
            n_q         <= n_d;
            den_q       <= den_d;
            k_q         <= k_d;
            p_q         <= p_d;
            pcnt_q      <= pcnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            exp_start_q <= exp_start_d;
            exp_x_q     <= exp_x_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        d_d         = d_q;
        res_d       = res_q;
        n_out_d     = n_out_q;
        x_d         = x_q;
        neg_d       = neg_q;
        a_d         = a_q;
        e_d         = e_q;
        n_d         = n_q;
        den_d       = den_q;
        k_d         = k_q;
        p_d         = p_q;
        pcnt_d      = pcnt_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        exp_start_d = exp_start_q;
        exp_x_d     = exp_x_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    d_d     = d_i;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    state_d = S_ABS;
                end
            end
            S_ABS: begin
`ifdef NORM_CLAMP_EN
                // Far tails: N is 0 or 1 to within Q precision, so skip the exponential.
                if (abs_x >= CLAMP) begin
                    res_d[ch_q] = d_cur[WIDTH-1] ? '0 : ONE;
                    if (last_ch) begin
                        state_d = S_DONE;
                    end else begin
                        ch_d    = ch_q + CW'(1);
                        state_d = S_ABS;
                    end
                end else begin
                    x_d     = abs_x;
                    neg_d   = d_cur[WIDTH-1];
                    state_d = S_SQ;
                end
`else
                x_d     = abs_x;
                neg_d   = d_cur[WIDTH-1];
                state_d = S_SQ;
`endif
            end
            S_SQ: begin
                a_d     = mul(x_q, x_q);
                state_d = S_HALF;
            end
            S_HALF: begin
                a_d     = a_q >> 1;
                state_d = S_EXP_REQ;
            end
            S_EXP_REQ: begin
                exp_x_d     = a_q;
                exp_start_d = 1'b1;
                state_d     = S_EXP_WAIT;
            end
            S_EXP_WAIT: begin
                if (exp_done_i) begin
                    e_d         = exp_y_i;
                    exp_start_d = 1'b0;
                    state_d     = S_NPRIME;
                end
            end
            S_NPRIME: begin
                n_d     = mul(C_INVS, e_q);
                state_d = S_GAMMA;
            end
            S_GAMMA: begin
                den_d   = ONE + mul(C_GAMMA, x_q);
                state_d = S_DIV;
            end
            S_DIV: begin
                // A wrapped denominator can only come from absurd |d|; saturate instead of X.
                if (den_q == '0) k_d = '1;
                else             k_d = WIDTH'(DIVIDEND / {{WIDTH{1'b0}}, den_q});
                pcnt_d  = '0;
                state_d = S_POLY;
            end
            S_POLY: begin
                pcnt_d = pcnt_q + 3'd1;
                case (pcnt_q)
                    3'd0:    p_d = C_A5;
                    3'd1:    p_d = C_A4 + mul(k_q, p_q);
                    3'd2:    p_d = C_A3 + mul(k_q, p_q);
                    3'd3:    p_d = C_A2 + mul(k_q, p_q);
                    default: begin
                        p_d     = mul(k_q, C_A1 + mul(k_q, p_q));
                        pcnt_d  = '0;
                        state_d = S_FINAL;
                    end
                endcase
            end
            S_FINAL: begin
                res_d[ch_q] = neg_q ? q_val : (ONE - q_val);
                if (last_ch) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = S_ABS;
                end
            end
            S_DONE: begin
                n_out_d = res_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign N_o         = n_out_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign exp_start_o = exp_start_q;
    assign exp_x_o     = exp_x_q;

endmodule

// File: tb/tb_norm_multi.sv
// Scoreboard bench for norm_multi: directed vectors, behavioural exponential responder.
module tb_norm_multi;
    localparam int W = 32;
    localparam int F = 16;
    localparam int C = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [C*W-1:0] d;
    logic [C*W-1:0] N;
    logic         done, busy, exp_start, exp_done;
    logic [W-1:0] exp_x, exp_y;

    always #5 clk = ~clk;

    norm_multi #(.WIDTH(W), .FRAC(F), .CHANNELS(C)) dut (
        .clk_i(clk), .reset_i(rst), .start_i(start), .d_i(d), .N_o(N),
        .done_o(done), .busy_o(busy), .exp_start_o(exp_start), .exp_x_o(exp_x),
        .exp_y_i(exp_y), .exp_done_i(exp_done)
    );

    typedef struct {
        logic [C*W-1:0] n;
        int             lat;
        int             t0;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int w_first = 3;
    int req_n = 0;
    int n_exp_starts = 0;
    bit prev_done = 1'b0;

    task automatic check(input string nm, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Exponential responder: returns round(2^F * e^-a) W cycles after exp_start rises.
    initial begin
        int cnt;
        logic [W-1:0] hx;
        real a;
        cnt = 0;
        hx = '0;
        exp_done = 1'b0;
        exp_y = '0;
        forever begin
            @(negedge clk);
            if (rst || !exp_start) begin
                cnt = 0;
                exp_done = 1'b0;
            end else begin
                cnt++;
                if (cnt == 1) begin
                    req_n++;
                    n_exp_starts++;
                    hx = exp_x;
                end else begin
                    check("exp_x_stable", exp_x == hx, exp_x, hx);
                end
                if (cnt == ((req_n == 1) ? w_first : 3)) begin
                    a = real'(exp_x) / 65536.0;
                    exp_y = W'($rtoi(65536.0 * $exp(-a) + 0.5));
                    exp_done = 1'b1;
                end else begin
                    exp_done = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse.
    initial forever begin
        @(negedge clk);
        if (!rst && done) begin
            check("done_single_pulse", !prev_done, prev_done, 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1'b0, 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                for (int c = 0; c < C; c++) begin
                    int dif;
                    dif = int'($signed(N[c*W +: W])) - int'($signed(e.n[c*W +: W]));
                    check($sformatf("N_ch%0d", c), (dif <= 32) && (dif >= -32), N[c*W +: W], e.n[c*W +: W]);
                end
                check("done_latency", (cyc - e.t0) == e.lat, cyc - e.t0, e.lat);
            end
        end
        prev_done = done;
    end

    // Issue one request at the current negedge and follow it to done.
    task automatic run(input logic [C*W-1:0] dv, input logic [C*W-1:0] nexp,
                       input int lat, input int nexps, input bit repulse);
        exp_t e;
        int k;
        bit seen;
        d = dv;
        start = 1'b1;
        req_n = 0;
        n_exp_starts = 0;
        e.n = nexp;
        e.lat = lat;
        e.t0 = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        d = ~dv;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 300) begin
            if (done) begin
                seen = 1'b1;
                check("busy_low_at_done", !busy, busy, 0);
            end else begin
                check("busy_high", busy, busy, 1);
                if (repulse && (k == 5 || k == 20)) begin
                    start = 1'b1;
                    d = {C{32'h0003_0000}};
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 1'b0, k, lat);
        check("exp_request_count", n_exp_starts == nexps, n_exp_starts, nexps);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        d = '0;
        repeat (3) @(negedge clk);
        check("reset_N", N == '0, N, 0);
        check("reset_done", done == 1'b0, done, 0);
        check("reset_busy", busy == 1'b0, busy, 0);
        check("reset_exp_start", exp_start == 1'b0, exp_start, 0);
        check("reset_exp_x", exp_x == '0, exp_x, 0);
        rst = 1'b0;
        @(negedge clk);

        run({32'h0, 32'h0}, {32'h8000, 32'h8000}, 33, 2, 1'b0);
        run({32'h0001_0000, 32'hFFFF_0000}, {32'h0000_D760, 32'h0000_28A0}, 33, 2, 1'b0);
        run({32'h0002_0000, 32'hFFFF_8000}, {32'h0000_FA2D, 32'h0000_4EFC}, 33, 2, 1'b0);
        @(negedge clk);
        run({32'hFFFF_0000, 32'h0001_0000}, {32'h0000_28A0, 32'h0000_D760}, 33, 2, 1'b1);

        w_first = 10;
        run({32'h0, 32'h0}, {32'h8000, 32'h8000}, 40, 2, 1'b0);
        w_first = 3;

        // Abort a request while it waits on the exponential.
        @(negedge clk);
        d = {32'h0001_0000, 32'h0001_0000};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && !exp_start; i++) @(negedge clk);
        check("exp_start_before_reset", exp_start, exp_start, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_exp_start", exp_start == 1'b0, exp_start, 0);
        check("midreset_busy", busy == 1'b0, busy, 0);
        check("midreset_N", N == '0, N, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run({32'h0001_0000, 32'hFFFF_0000}, {32'h0000_D760, 32'h0000_28A0}, 33, 2, 1'b0);

`ifdef NORM_CLAMP_EN
        run({32'h0007_0000, 32'hFFF9_0000}, {32'h0001_0000, 32'h0}, 3, 0, 1'b0);
`else
        run({32'h0007_0000, 32'hFFF9_0000}, {32'h0001_0000, 32'h0}, 33, 2, 1'b0);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size() == 0, sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/norm_multi.md
# norm_multi

Multi-channel cumulative-normal unit for the pricing datapath. It computes N(d) for CHANNELS signed fixed-point inputs per request, using the Abramowitz–Stegun 5-term polynomial. Channels are processed sequentially through one multiplier/divider datapath. The exponential is requested over an external handshake, so a single `exponential` instance can be shared and arbitrated at top level. It supersedes the single-input normal block: width, fraction bits and channel count are generalised, the d ≥ 0 branch computes N = 1 − n(d)·P(k), and `done` is a strict one-cycle pulse.

## Interface
- WIDTH, 32, data word width (signed, two's complement).
- FRAC, 16, fraction bits; value v encodes v/2^FRAC.
- CHANNELS, 2, number of inputs per request (≥1).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- d  in  CHANNELS*WIDTH  inputs; channel i at [i*WIDTH +: WIDTH], latched on accepted start.
- N  out  CHANNELS*WIDTH  results, same packing; all channels update together.
- done  out  1  one-cycle pulse when all N are valid.
- busy  out  1  high from accepted start until the cycle done pulses.
- exp_start  out  1  exponential request level.
- exp_x  out  WIDTH  magnitude a = x²/2 (≥0); exponential must return e^(−a).
- exp_y  in  WIDTH  exponential result, Q format as above.
- exp_done  in  1  exponential completion, sampled high for ≥1 cycle.

## Operation
- Constants are rounded from reals to FRAC bits: gamma 0.2316419, 1/√(2π) 0.39894228, a1..a5 0.31938153, −0.35656378, 1.78147794, −1.82125598, 1.33027443, one = 1<<FRAC.
- Multiply: full 2*WIDTH signed product, result = product[FRAC+WIDTH-1:FRAC] (truncate, no saturation).
- Divide: k = (one<<FRAC) / (one + gamma·x), unsigned, quotient truncated.
- FSM per channel, channel index ch from 0 to CHANNELS−1:
  - IDLE: on start, latch all d, ch=0, busy=1 → ABS.
  - ABS: x = |d[ch]|, neg = sign → SQ.
  - SQ: x² → HALF.
  - HALF: a = x²/2 → EXP_REQ.
  - EXP_REQ: exp_x = a, exp_start=1 → EXP_WAIT.
  - EXP_WAIT: hold exp_start, exp_x. On exp_done=1: capture exp_y, drop exp_start next edge → NPRIME.
  - NPRIME: n = inv_sqrt_2pi·e → GAMMA.
  - GAMMA: one + gamma·x → DIV.
  - DIV: k → POLY.
  - POLY: Horner, 5 cycles, p = a5; then p = a(j) + k·p for j=4..1; then p = k·p. The last step shares the 5th cycle's register: p_final = k·(a1 + k·p).
  - FINAL: q = n·p; result[ch] = neg ? q : one − q; then ch==CHANNELS−1 → DONE, else ch+1 → ABS.
  - DONE: N ← all results, done=1, busy=0 → IDLE.
- start while busy is ignored; the latched d is unaffected.

## Timing
- Reset values: N=0, done=0, busy=0, exp_start=0, exp_x=0, FSM in IDLE, ch=0.
- Per channel: ABS, SQ, HALF, EXP_REQ, (W wait cycles), NPRIME, GAMMA, DIV, POLY×5, FINAL = 13+W cycles. W ≥ 1 is the number of EXP_WAIT cycles up to and including the one where exp_done is sampled.
- Total: done asserts CHANNELS·13 + ΣW + 1 cycles after the start edge.
- exp_start rises the edge after EXP_REQ and falls the edge after exp_done is sampled. It never re-rises for the same channel.
- exp_done high outside EXP_WAIT is ignored.
- A new start is accepted in IDLE the cycle after done (back-to-back legal).
- Reset mid-operation: immediate return to reset values; a pending exponential request is abandoned (exp_start low).

## Configuration
- NORM_CLAMP_EN defined: in ABS, if x ≥ (6<<FRAC), the channel skips SQ through FINAL. result = neg ? 0 : one, in one cycle (ABS → next channel/DONE), with no exp_start for that channel.
- NORM_CLAMP_EN undefined: every channel takes the full path regardless of magnitude.

## Test plan
Bench exponential model returns round(2^FRAC·e^(−a)) after 3 cycles, defaults WIDTH=32, FRAC=16, CHANNELS=2.
- d = {0, 0} → N = {0x8000, 0x8000} ±0x20; done single pulse at cycle 2·(13+3)+1 = 33; busy high cycles 1–32.
- d = {0x00010000, 0xFFFF0000} (+1, −1) → N = {0xD760, 0x28A0} ±0x20. Exercises both symmetry branches.
- start re-pulsed at cycle 5 and cycle 20 → ignored, result equals single-request result, one done pulse.
- exp model delays exp_done 10 cycles on channel 0 → exp_start held, exp_x stable throughout; done at cycle 2·13+10+3+1 = 40.
- reset asserted during EXP_WAIT → next edge: exp_start=0, busy=0, N=0. A subsequent start runs correctly.
- NORM_CLAMP_EN, d = {0x00070000, 0xFFF90000} → N = {0x00010000, 0}, no exp_start pulses, done at cycle 3. Undefined: N ≈ {0x10000, 0} ±0x20 via the full path.
